// File: rtl/matvec_engine.sv
// Pipelined matrix-vector engine: y = A*x or y += A*x over on-chip A, x and y stores.
// Stages: memory read, registered signed multiply, accumulate/retire into y.
module matvec_engine #(
  parameter int ROWS    = 30,
  parameter int COLS    = 30,
  parameter int DW      = 32,
  parameter int ACC_W   = 2*DW + $clog2(COLS),
  parameter int RET_ROW = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  acc_mode,
  input  logic                                                  wr_en,
  input  logic                                                  wr_sel,
  input  logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] wr_addr,
  input  logic [DW-1:0]                                         wr_data,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]            rd_addr,
  output logic [ACC_W-1:0]                                      rd_data,
  output logic                                                  busy,
  output logic                                                  finish,
  output logic [31:0]                                           return_val,
  output logic                                                  wr_err
);

  localparam int          N  = ROWS*COLS;
  localparam int          AW = (N > 1) ? $clog2(N) : 1;
  localparam int          RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int          JW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned NU = N;
  localparam int unsigned CU = COLS;
  localparam int unsigned RU = ROWS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept, last_issue, busy_nxt, finish_nxt;
  logic   oor, wr_ok, mode;

  logic [AW-1:0] idx;
  logic [RW-1:0] row, s1_row, s2_row;
  logic [JW-1:0] col, s1_col, s2_col;
  logic [1:0]    dcnt;
  logic          s1_v, s2_v;

  logic signed [DW-1:0]    a_mem [N];
  logic signed [DW-1:0]    x_mem [COLS];
  logic signed [ACC_W-1:0] y_mem [ROWS];

  logic signed [DW-1:0]    s1_a, s1_x;
  logic signed [2*DW-1:0]  s2_p;
  logic signed [ACC_W-1:0] acc, acc_base, acc_sum, rd_word;

  // busy/finish are registered one edge after DONE is entered, so start is only
  // accepted once the previous run's status has settled.
  always_comb begin
    accept     = start && !busy;
    last_issue = (idx == AW'(N-1));
    state_nxt  = state;
    busy_nxt   = busy;
    finish_nxt = finish;
    case (state)
      IDLE, DONE: if (accept) state_nxt = RUN;
      RUN:        if (last_issue) state_nxt = DRAIN;
      DRAIN:      if (dcnt == 2'd2) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (accept) begin
      busy_nxt   = 1'b1;
      finish_nxt = 1'b0;
    end else if (state == DONE) begin
      busy_nxt   = 1'b0;
      finish_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      finish <= finish_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      row  <= '0;
      col  <= '0;
      dcnt <= '0;
    end else begin
      if (accept) begin
        idx <= '0;
        row <= '0;
        col <= '0;
      end else if (state == RUN) begin
        idx <= idx + 1'b1;
        if (col == JW'(COLS-1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    oor   = wr_sel ? (32'(wr_addr) >= CU) : (32'(wr_addr) >= NU);
    wr_ok = wr_en && !busy && !oor;
  end

  // A and x keep their contents across reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel) a_mem[wr_addr] <= wr_data;
    if (wr_ok && wr_sel)  x_mem[wr_addr[JW-1:0]] <= wr_data;
    if (state == RUN) begin
      s1_a <= a_mem[idx];
      s1_x <= x_mem[col];
    end
  end

  always_comb begin
    acc_base = acc;
    if (s2_col == '0) acc_base = mode ? y_mem[s2_row] : '0;
    acc_sum = acc_base + ACC_W'(s2_p);
    rd_word = (32'(rd_addr) < RU) ? y_mem[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode    <= 1'b0;
      s1_v    <= 1'b0;
      s1_row  <= '0;
      s1_col  <= '0;
      s2_v    <= 1'b0;
      s2_row  <= '0;
      s2_col  <= '0;
      s2_p    <= '0;
      acc     <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
      for (int unsigned r = 0; r < RU; r++) y_mem[r] <= '0;
    end else begin
      if (accept) mode <= acc_mode;
      s1_v   <= (state == RUN);
      s1_row <= row;
      s1_col <= col;
      s2_v   <= s1_v;
      s2_row <= s1_row;
      s2_col <= s1_col;
      s2_p   <= (2*DW)'(s1_a) * (2*DW)'(s1_x);
      if (s2_v) begin
        acc <= acc_sum;
        if (s2_col == JW'(COLS-1)) y_mem[s2_row] <= acc_sum;
      end
      rd_data <= busy_nxt ? '0 : rd_word;
      wr_err  <= wr_en && (busy || oor);
    end
  end

  generate
    if (ACC_W >= 32) begin : g_ret_trunc
      assign return_val = y_mem[RET_ROW][31:0];
    end else begin : g_ret_sext
      assign return_val = 32'(y_mem[RET_ROW]);
    end
  endgenerate

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine (2x3, 8-bit): stimulus pushes expectations,
// a negedge monitor compares finish timing, return_val, rd_data and wr_err.
`timescale 1ns/1ps
module tb_matvec_engine;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int DW    = 8;
  localparam int ACC_W = 2*DW + 2;
  localparam int N     = ROWS*COLS;
  localparam int LAT   = N + 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             acc_mode = 1'b0;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [2:0]       wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [0:0]       rd_addr = '0;
  logic [ACC_W-1:0] rd_data;
  logic             busy, finish, wr_err;
  logic [31:0]      return_val;

  matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W), .RET_ROW(0)) dut (
    .clk(clk), .reset(rst_n), .start(start), .acc_mode(acc_mode),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .finish(finish),
    .return_val(return_val), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int     a_m [N];
  int     x_m [COLS];
  longint y_m [ROWS];
  int     run_start = -1000;

  typedef struct { int start_edge; longint exp_ret; } run_t;
  typedef struct { int due; int row; longint exp; } rd_t;
  run_t run_q [$];
  rd_t  rd_q  [$];
  int   err_q [$];

  function automatic longint wrap(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'($signed(t));
  endfunction

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // busy is high in the cycle after edge c for a run whose start was sampled at run_start
  function automatic bit busy_at(input int c);
    return (c >= run_start) && (c < run_start + LAT);
  endfunction

  task automatic drive_wr(input logic sel, input int addr, input int val);
    int c;
    c = cyc;
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[2:0];
    wr_data = val[DW-1:0];
    if (busy_at(c) || (sel ? (addr >= COLS) : (addr >= N))) err_q.push_back(c + 1);
    else if (sel) x_m[addr] = val;
    else a_m[addr] = val;
  endtask

  task automatic write(input logic sel, input int addr, input int val);
    drive_wr(sel, addr, val);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic mode, input bit with_wr, input logic sel,
                           input int addr, input int val);
    int     c;
    longint s;
    c = cyc;
    if (with_wr) drive_wr(sel, addr, val);
    start    = 1'b1;
    acc_mode = mode;
    if (!busy_at(c)) begin
      for (int i = 0; i < ROWS; i++) begin
        s = 0;
        for (int j = 0; j < COLS; j++) s += longint'(a_m[i*COLS+j]) * longint'(x_m[j]);
        y_m[i] = wrap(mode ? y_m[i] + s : s);
      end
      run_start = c + 1;
      run_q.push_back('{start_edge: c + 1, exp_ret: y_m[0]});
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!(finish && !busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("finish_timeout", longint'(finish), 1);
  endtask

  task automatic rd(input int r);
    int c;
    c = cyc;
    rd_addr = r[0:0];
    rd_q.push_back('{due: c + 1, row: r, exp: busy_at(c + 1) ? 0 : y_m[r]});
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int r = 0; r < ROWS; r++) rd(r);
  endtask

  task automatic run_and_read(input logic mode);
    start_run(mode, 1'b0, 1'b0, 0, 0);
    wait_finish();
    read_all();
  endtask

  // Monitor
  logic fin_q = 1'b0;
  always @(negedge clk) begin : monitor
    run_t r;
    rd_t  e;
    bit   exp_err;
    if (finish && !fin_q) begin
      if (run_q.size() == 0) begin
        check("unexpected_finish", 1, 0);
      end else begin
        r = run_q.pop_front();
        check("finish_latency", longint'(cyc - r.start_edge), LAT);
        check("return_val", longint'($signed(return_val)), r.exp_ret);
        check("busy_at_finish", longint'(busy), 0);
      end
    end
    fin_q = finish;
    if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      check($sformatf("rd_data_row%0d", e.row), longint'($signed(rd_data)), e.exp);
    end
    exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
    if (exp_err) void'(err_q.pop_front());
    if (exp_err || wr_err) check("wr_err", longint'(wr_err), longint'(exp_err));
  end

  initial begin
    for (int i = 0; i < ROWS; i++) y_m[i] = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", longint'(busy), 0);
    check("reset_finish", longint'(finish), 0);
    check("reset_rd_data", longint'(rd_data), 0);
    check("reset_return_val", longint'(return_val), 0);
    check("reset_wr_err", longint'(wr_err), 0);
    rst_n = 1'b1;

    for (int k = 0; k < N; k++) write(1'b0, k, k + 1);
    for (int j = 0; j < COLS; j++) write(1'b1, j, 1);

    run_and_read(1'b0);   // [6,15]
    run_and_read(1'b1);   // [12,30]
    run_and_read(1'b0);   // [6,15]

    // Start and x load while busy are ignored; rd_data reads 0 mid-run
    start_run(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    start_run(1'b1, 1'b0, 1'b0, 0, 0);
    rd(1);
    write(1'b1, 0, 99);
    wait_finish();
    read_all();

    // Out-of-range loads
    write(1'b0, 6, 77);
    write(1'b1, 3, 5);
    run_and_read(1'b0);

    // Reset mid-run
    start_run(1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_finish", longint'(finish), 0);
    check("abort_rd_data", longint'(rd_data), 0);
    check("abort_return_val", longint'(return_val), 0);
    for (int i = 0; i < ROWS; i++) y_m[i] = 0;
    run_q.delete();
    run_start = -1000;
    @(negedge clk);
    rst_n = 1'b1;
    read_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_run(1'b0, 1'b0, 1'b0, 0, 0);
    wait_finish();
    read_all();

    // Most negative operands
    for (int k = 0; k < N; k++) write(1'b0, k, -128);
    for (int j = 0; j < COLS; j++) write(1'b1, j, -128);
    run_and_read(1'b0);   // 49152 each

    // Randomized loads (some out of range) and runs, some with a simultaneous load
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 3; w++) begin
        if ($urandom_range(1, 0) == 1) write(1'b1, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)) - 128);
        else write(1'b0, int'($urandom_range(7, 0)), int'($urandom_range(255, 0)) - 128);
      end
      start_run(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                int'($urandom_range(2, 0)), int'($urandom_range(255, 0)) - 128);
      wait_finish();
      read_all();
    end

    repeat (3) @(negedge clk);
    check("pending_runs", longint'(run_q.size()), 0);
    check("pending_reads", longint'(rd_q.size()), 0);
    check("pending_wr_err", longint'(err_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
